// File: rtl/alu_pkg.sv
// ALU shared types: operation encoding and NZCV flag bit positions.
// Imported by alu_flag_gen and alu_unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_MUL = 5'd3,
    OP_MOV = 5'd4,
    OP_DIV = 5'd5,
    OP_LSL = 5'd6,
    OP_LSR = 5'd7,
    OP_ASR = 5'd8,
    OP_AND = 5'd9,
    OP_OR  = 5'd10,
    OP_XOR = 5'd11,
    OP_NOT = 5'd12
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generator for alu_unit.
// Ports: op, a_msb/b_msb, sum_msb/carry (raw adder), shift_c, b_zero, result -> nzcv.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       op,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             sum_msb,
  input  logic             carry,
  input  logic             shift_c,
  input  logic             b_zero,
  input  logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  alu_op_e op_e;
  assign op_e = alu_op_e'(op);

  always_comb begin
    nzcv         = '0;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = ~|result;
    case (op_e)
      OP_ADD: begin
        nzcv[FLAG_C] = carry;
        nzcv[FLAG_V] = (a_msb == b_msb) && (sum_msb != a_msb);
      end
      OP_SUB: begin
        // carry out of A + ~B + 1 is the no-borrow flag
        nzcv[FLAG_C] = carry;
        nzcv[FLAG_V] = (a_msb != b_msb) && (sum_msb != a_msb);
      end
      OP_DIV: nzcv[FLAG_V] = b_zero;
      OP_LSL, OP_LSR, OP_ASR: nzcv[FLAG_C] = shift_c;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Registered integer ALU: result and NZCV one clock after operands.
// Ports: clk, rst_n, alu_ctrl, srcA, srcB -> result, alu_flags. Macro: ALU_SHIFT_OPS_EN.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  alu_op_e op;
  assign op = alu_op_e'(alu_ctrl);

  logic             sub;
  logic             b_zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot;
  logic             shift_c;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;

  assign sub    = (op == OP_SUB);
  assign b_zero = ~|srcB;
  // shared adder: SUB as A + ~B + 1
  assign sum    = {1'b0, srcA}
                + {1'b0, sub ? ~srcB : srcB}
                + {{WIDTH{1'b0}}, sub};
  assign prod   = srcA * srcB;
  assign quot   = b_zero ? '1 : srcA / srcB;

`ifdef ALU_SHIFT_OPS_EN
  logic [4:0]     amt;
  logic [WIDTH:0] lsl_w;
  logic [WIDTH:0] lsr_w;
  logic [WIDTH:0] asr_w;

  // one guard bit catches the last bit shifted out
  assign amt   = srcB[4:0];
  assign lsl_w = {1'b0, srcA} << amt;
  assign lsr_w = {srcA, 1'b0} >> amt;
  assign asr_w = $unsigned($signed({srcA, 1'b0}) >>> amt);

  always_comb begin
    shift_c = 1'b0;
    case (op)
      OP_LSL:  shift_c = lsl_w[WIDTH];
      OP_LSR:  shift_c = lsr_w[0];
      OP_ASR:  shift_c = asr_w[0];
      default: shift_c = 1'b0;
    endcase
  end
`else
  assign shift_c = 1'b0;
`endif

  always_comb begin
    res_d = '0;
    case (op)
      OP_ADD:  res_d = sum[WIDTH-1:0];
      OP_SUB:  res_d = sum[WIDTH-1:0];
      OP_MUL:  res_d = prod;
      OP_MOV:  res_d = srcA;
      OP_DIV:  res_d = quot;
      OP_AND:  res_d = srcA & srcB;
      OP_OR:   res_d = srcA | srcB;
      OP_XOR:  res_d = srcA ^ srcB;
      OP_NOT:  res_d = ~srcA;
`ifdef ALU_SHIFT_OPS_EN
      OP_LSL:  res_d = lsl_w[WIDTH-1:0];
      OP_LSR:  res_d = lsr_w[WIDTH:1];
      OP_ASR:  res_d = asr_w[WIDTH:1];
`endif
      default: res_d = '0;
    endcase
  end

  alu_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .op     (alu_ctrl),
    .a_msb  (srcA[WIDTH-1]),
    .b_msb  (srcB[WIDTH-1]),
    .sum_msb(sum[WIDTH-1]),
    .carry  (sum[WIDTH]),
    .shift_c(shift_c),
    .b_zero (b_zero),
    .result (res_d),
    .nzcv   (flags_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      alu_flags <= '0;
    end else begin
      result    <= res_d;
      alu_flags <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: behavioural model, random + directed.
// Outputs compared every falling edge; directed literals pin the model.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  alu_ctrl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] result;
  logic [3:0]  alu_flags;

  int checks   = 0;
  int failures = 0;

  logic [35:0] exp_out = '0;

  alu_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_ctrl (alu_ctrl),
    .srcA     (srcA),
    .srcB     (srcB),
    .result   (result),
    .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] model(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic        v;
    logic [63:0] w;
    longint      sa;
    longint      sb;
    longint      sr;
    int          n;
    r  = 32'd0;
    c  = 1'b0;
    v  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    case (int'(op))
      1: begin
        w  = 64'(a) + 64'(b);
        r  = w[31:0];
        c  = w[32];
        sr = sa + sb;
        v  = (sr != longint'($signed(r)));
      end
      2: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr != longint'($signed(r)));
      end
      3: begin
        w = 64'(a) * 64'(b);
        r = w[31:0];
      end
      4: r = a;
      5: begin
        if (b == 32'd0) begin
          r = 32'hFFFF_FFFF;
          v = 1'b1;
        end else begin
          r = a / b;
        end
      end
`ifdef ALU_SHIFT_OPS_EN
      6: begin
        r = a << n;
        c = (n != 0) ? a[32-n] : 1'b0;
      end
      7: begin
        r = a >> n;
        c = (n != 0) ? a[n-1] : 1'b0;
      end
      8: begin
        r = $unsigned($signed(a) >>> n);
        c = (n != 0) ? a[n-1] : 1'b0;
      end
`endif
      9:  r = a & b;
      10: r = a | b;
      11: r = a ^ b;
      12: r = ~a;
      default: r = 32'd0;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  // expected register contents, cleared by reset just like the outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_out <= '0;
    else        exp_out <= model(alu_ctrl, srcA, srcB);
  end

  always @(negedge clk) begin
    checks++;
    if ({result, alu_flags} !== exp_out) begin
      failures++;
      $display("FAIL model_cmp op=%0d got=%h/%b want=%h/%b",
               alu_ctrl, result, alu_flags, exp_out[35:4], exp_out[3:0]);
    end
  end

  task automatic check_lit(input string name,
                           input logic [31:0] got_r, input logic [3:0] got_f,
                           input logic [31:0] want_r, input logic [3:0] want_f);
    checks++;
    if (got_r !== want_r || got_f !== want_f) begin
      failures++;
      $display("FAIL %s got=%h/%b want=%h/%b", name, got_r, got_f, want_r, want_f);
    end
  endtask

  task automatic apply(input string name, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want_r, input logic [3:0] want_f);
    logic [35:0] m;
    @(negedge clk);
    alu_ctrl = op;
    srcA     = a;
    srcB     = b;
    m = model(op, a, b);
    check_lit({name, "_model"}, m[35:4], m[3:0], want_r, want_f);
    @(posedge clk);
    #1;
    check_lit(name, result, alu_flags, want_r, want_f);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n    = 1'b0;
    alu_ctrl = 5'd1;
    srcA     = 32'h1234_5678;
    srcB     = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    check_lit("reset_state", result, alu_flags, 32'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("add_1_5",     5'd1,  32'd1,          32'd5, 32'd6,          4'b0000);
    apply("add_ovf",     5'd1,  32'h7FFF_FFFF,  32'd1, 32'h8000_0000,  4'b1001);
    apply("add_carry",   5'd1,  32'hFFFF_FFFF,  32'd1, 32'd0,          4'b0110);
    apply("sub_2_1",     5'd2,  32'd2,          32'd1, 32'd1,          4'b0010);
    apply("sub_1_2",     5'd2,  32'd1,          32'd2, 32'hFFFF_FFFF,  4'b1000);
    apply("sub_ovf",     5'd2,  32'h8000_0000,  32'd1, 32'h7FFF_FFFF,  4'b0011);
    apply("mul_2_8",     5'd3,  32'd2,          32'd8, 32'd16,         4'b0000);
    apply("mov_15",      5'd4,  32'd15,         32'd9, 32'd15,         4'b0000);
    apply("div_16_4",    5'd5,  32'd16,         32'd4, 32'd4,          4'b0000);
    apply("div_by_0",    5'd5,  32'd16,         32'd0, 32'hFFFF_FFFF,  4'b1001);
    apply("and_1_1",     5'd9,  32'd1,          32'd1, 32'd1,          4'b0000);
    apply("or_0_1",      5'd10, 32'd0,          32'd1, 32'd1,          4'b0000);
    apply("xor_0_1",     5'd11, 32'd0,          32'd1, 32'd1,          4'b0000);
    apply("not_0",       5'd12, 32'd0,          32'd7, 32'hFFFF_FFFF,  4'b1000);
    apply("reserved_13", 5'd13, 32'd5,          32'd3, 32'd0,          4'b0100);
    apply("nop",         5'd0,  32'd5,          32'd3, 32'd0,          4'b0100);
`ifdef ALU_SHIFT_OPS_EN
    apply("asr_8000",    5'd8,  32'h8000_0000,  32'd4, 32'hF800_0000,  4'b1000);
    apply("lsl_carry",   5'd6,  32'hC000_0000,  32'd1, 32'h8000_0000,  4'b1010);
    apply("lsr_carry",   5'd7,  32'd3,          32'd1, 32'd1,          4'b0010);
`else
    apply("reserved_6",  5'd6,  32'd5,          32'd3, 32'd0,          4'b0100);
`endif

    // async reset pulse between edges
    apply("pre_reset",   5'd1,  32'd1,          32'd5, 32'd6,          4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    check_lit("async_reset", result, alu_flags, 32'd0, 4'b0000);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_lit("post_reset_capture", result, alu_flags, 32'd6, 4'b0000);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      alu_ctrl = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) alu_ctrl = 5'($urandom_range(1, 2));
      srcA = pick();
      srcB = pick();
    end
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
